wb_sram_slave: RTL and testbench
================================

Name: wb_sram_slave

Overview:
Wishbone pipelined-mode responder wrapping a synchronous single-port word RAM. It serves the memory stage and other bus masters through the shared if_wb fabric, as the target side of their LOAD/STORE/PUSH/POP/exception-frame cycles. Big-endian byte lanes: sel[3] maps to dat[31:24], which is byte offset 0. After reset it clears its RAM before accepting traffic. Acks return in order at a fixed latency.

Parameters:
AWIDTH, 12, word-address bits; capacity is 2^AWIDTH 32-bit words; adr_i[AWIDTH+1:2] indexes RAM.
LATENCY, 1, cycles from the accepting edge to ack_o; legal values 1..3; other values are a elaboration error.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  asynchronous, active-high reset.
cyc_i  in  1  bus cycle valid.
stb_i  in  1  strobe; request present.
we_i  in  1  1 = write, 0 = read.
sel_i  in  4  byte lane enables, big-endian lanes.
adr_i  in  32  byte address; bits [1:0] ignored.
dat_i  in  32  write data from master.
dat_o  out  32  read data; valid only in the ack_o cycle.
ack_o  out  1  transfer complete.
stall_o  out  1  request not accepted this cycle.
err_o  out  1  error termination; only active with the optional feature.

Behaviour:
- Reset (async): state=S_CLEAR, clear counter=0, ack_o=0, err_o=0, dat_o=0, stall_o=1, pipeline valid bits=0. RAM contents are not reset asynchronously.
- S_CLEAR: writes 0 to word [counter] each cycle and increments the counter. stall_o=1 and ack_o=0. Requests are ignored, not queued. After the write to word 2^AWIDTH-1 the block goes to S_RUN. stall_o drops on the first S_RUN cycle. Total time is exactly 2^AWIDTH cycles after reset release.
- S_RUN: stall_o=0 combinationally. A request is accepted on any edge with cyc_i & stb_i & !stall_o. One accept per cycle; back-to-back accepts are legal.
- Write: on the accepting edge, each lane with sel_i[n]=1 writes its byte to RAM. Lanes with sel_i[n]=0 are untouched. sel_i=0 is a legal no-op write and is still acked.
- Read: returns the full 32-bit word regardless of sel_i; the master extracts lanes.
- Latency: an accept on edge N gives ack_o=1 for exactly the cycle after edge N+LATENCY-1. With LATENCY=1, ack is high in the cycle following the accept. This uses a LATENCY-deep shift register of {valid, we, err, addr}. Read data is captured at the final stage, so dat_o is registered.
- Ordering: acks are strictly in accept order, one per accept. There is never more than one ack per cycle.
- Read-after-write: a read accepted on the edge after a write to the same word returns the new data; the RAM write commits at the accept edge.
- Abort: if cyc_i=0 in any cycle, all in-flight valid bits clear on that edge and no ack/err is issued for them. Writes already committed stay committed.
- ack_o and err_o are never both 1. Both are 0 whenever cyc_i was low on the preceding edge.
- dat_o holds its last value when ack_o=0.
- Reset mid-operation (either state) returns to S_CLEAR and restarts the clear from word 0. Pending acks are dropped.

Optional Feature:
Macro WB_SRAM_ERR_EN.
- Defined: a request with any of adr_i[31:AWIDTH+2] nonzero is out of range. It is accepted normally but does not write RAM. It terminates with err_o=1 (instead of ack_o) at the same latency, with dat_o=0.
- Undefined: upper address bits are ignored (addresses alias modulo 2^(AWIDTH+2) bytes), err_o is tied 0, and no range-compare logic exists.

Test Plan:
- Reset then idle, AWIDTH=4: stall_o=1 for exactly 16 cycles after reset release, then 0. A read of any word (e.g. 0x3C) acks with dat_o=0x00000000.
- Full word write then read, LATENCY=1: write adr 0x10 = 0xDEADBEEF, sel 4'hf -> ack next cycle. Read 0x10 -> ack next cycle with dat_o=0xDEADBEEF.
- Byte and half lanes: after word 0x20 = 0x00000000, write sel 4'b1000 dat 0xAA000000, then write sel 4'b0011 dat 0x00001234. Read 0x20 -> 0xAA001234.
- Pipelined burst, LATENCY=3: 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC (preloaded 1..4) -> ack high on 4 consecutive cycles starting 3 cycles after the first accept, dat_o = 1, 2, 3, 4 in order.
- Abort, LATENCY=3: accept 2 reads, drop cyc_i on the next cycle -> no ack ever asserted. A following new cycle acks normally.
- WB_SRAM_ERR_EN, AWIDTH=4: write 0x100 = 0x55 -> err_o=1, ack_o=0. Read 0x000 still returns its prior value (no alias write).

Source files
------------

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone pipelined responder over a word RAM with fixed-latency in-order acks
// Optional: define WB_SRAM_ERR_EN to terminate out-of-range requests with err_o.
module wb_sram_slave #(
  parameter int AWIDTH  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("wb_sram_slave: LATENCY must be in 1..3");
  end

  localparam int WORDS = 1 << AWIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] clr_q, clr_d;

  logic [31:0]       mem [WORDS];
  logic              mem_we;
  logic [AWIDTH-1:0] mem_wadr;
  logic [31:0]       mem_wdat;
  logic [3:0]        mem_wbe;

  logic              accept;
  logic              req_err;
  logic [AWIDTH-1:0] req_adr;

  logic [LATENCY-1:0] v_q, v_d;
  logic [LATENCY-1:0] we_q, we_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [AWIDTH-1:0]  adr_q [LATENCY];
  logic [AWIDTH-1:0]  adr_d [LATENCY];
  logic [31:0]        dat_q;

  assign req_adr = adr_i[AWIDTH+1:2];

`ifdef WB_SRAM_ERR_EN
  assign req_err = |adr_i[31:AWIDTH+2];
  logic unused_adr;
  assign unused_adr = ^adr_i[1:0];
`else
  assign req_err = 1'b0;
  logic unused_adr;
  assign unused_adr = ^{adr_i[31:AWIDTH+2], adr_i[1:0]};
`endif

  // The clear sweep and bus writes share the single RAM write port.
  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    stall_o  = 1'b1;
    accept   = 1'b0;
    mem_we   = 1'b0;
    mem_wadr = clr_q;
    mem_wdat = '0;
    mem_wbe  = 4'hf;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        clr_d  = clr_q + AWIDTH'(1);
        if (&clr_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        stall_o  = 1'b0;
        accept   = cyc_i & stb_i;
        mem_we   = cyc_i & stb_i & we_i & ~req_err;
        mem_wadr = req_adr;
        mem_wdat = dat_i;
        mem_wbe  = sel_i;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Big-endian lanes fall out naturally: sel bit n guards dat[8n+7:8n].
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wbe[b]) begin
          mem[mem_wadr][8*b +: 8] <= mem_wdat[8*b +: 8];
        end
      end
    end
  end

  // Dropping cyc_i kills every in-flight request on that edge.
  always_comb begin
    v_d[0]   = accept;
    we_d[0]  = we_i;
    err_d[0] = req_err;
    adr_d[0] = req_adr;
    for (int i = 1; i < LATENCY; i++) begin
      v_d[i]   = v_q[i-1];
      we_d[i]  = we_q[i-1];
      err_d[i] = err_q[i-1];
      adr_d[i] = adr_q[i-1];
    end
    if (!cyc_i) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q   <= '0;
      we_q  <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        adr_q[i] <= '0;
      end
      dat_q <= '0;
    end else begin
      v_q   <= v_d;
      we_q  <= we_d;
      err_q <= err_d;
      adr_q <= adr_d;
      // Read data is sampled as the request enters the final stage.
      if (v_d[LATENCY-1]) begin
        if (err_d[LATENCY-1]) begin
          dat_q <= '0;
        end else if (!we_d[LATENCY-1]) begin
          dat_q <= mem[adr_d[LATENCY-1]];
        end
      end
    end
  end

  assign dat_o = dat_q;
  assign ack_o = v_q[LATENCY-1] & ~err_q[LATENCY-1];

`ifdef WB_SRAM_ERR_EN
  assign err_o = v_q[LATENCY-1] & err_q[LATENCY-1];
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - scoreboard bench for wb_sram_slave at LATENCY 1 and 3, AWIDTH 4
module tb_wb_sram_slave;

  localparam int AW = 4;
`ifdef WB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int          tag;
    logic        we;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] dat_w   [2];
  logic        ack_w   [2];
  logic        err_w   [2];
  logic        stall_w [2];

  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  wb_sram_slave #(.AWIDTH(AW), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(wdat), .dat_o(dat_w[0]), .ack_o(ack_w[0]),
    .stall_o(stall_w[0]), .err_o(err_w[0])
  );

  wb_sram_slave #(.AWIDTH(AW), .LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(wdat), .dat_o(dat_w[1]), .ack_o(ack_w[1]),
    .stall_o(stall_w[1]), .err_o(err_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a);
    return (|a[31:AW+2]) & ERR_EN;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference memory: cleared by reset, byte-merged on accepted in-range writes.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] <= '0;
    end else if (cyc && stb && !stall_w[0] && we && !exp_err(adr)) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) model[adr[5:2]][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int LAT = (g == 0) ? 1 : 3;
    exp_t q[$];

    always @(posedge clk) begin
      exp_t e;
      if (rst || !cyc) begin
        q.delete();
      end else if (stb && !stall_w[g]) begin
        e.tag  = cyc_cnt + 1;
        e.we   = we;
        e.err  = exp_err(adr);
        e.data = exp_err(adr) ? 32'h0 : model[adr[5:2]];
        q.push_back(e);
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        q.delete();
      end else if (ack_w[g] || err_w[g]) begin
        chk($sformatf("L%0d ack_expected", LAT), 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk($sformatf("L%0d latency", LAT), 32'(cyc_cnt), 32'(e.tag + LAT - 1));
          chk($sformatf("L%0d err_o", LAT), 32'(err_w[g]), 32'(e.err));
          chk($sformatf("L%0d ack_o", LAT), 32'(ack_w[g]), 32'(!e.err));
          if (!e.we || e.err) chk($sformatf("L%0d dat_o", LAT), dat_w[g], e.data);
        end
      end else if (q.size() != 0 && q[0].tag + LAT - 1 <= cyc_cnt) begin
        chk($sformatf("L%0d missing_ack", LAT), 32'(ack_w[g] | err_w[g]), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    tick();
  endtask

  task automatic idle(input int n);
    stb = 1'b0; we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic release_and_count(input string tag);
    int n;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_w[0] && n < 100);
    chk({tag, "_stall_cycles"}, 32'(n), 32'd16);
    chk({tag, "_stall_L3"}, 32'(stall_w[1]), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_stall%0d", i), 32'(stall_w[i]), 32'd1);
      chk($sformatf("rst_ack%0d", i), 32'(ack_w[i]), 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(err_w[i]), 32'd0);
      chk($sformatf("rst_dat%0d", i), dat_w[i], 32'd0);
    end
    release_and_count("init");

    req(1'b0, 32'h3C, 4'hf, 32'h0);
    idle(4);

    req(1'b1, 32'h10, 4'hf, 32'hDEADBEEF);
    req(1'b0, 32'h10, 4'hf, 32'h0);
    idle(4);

    req(1'b1, 32'h20, 4'hf, 32'h00000000);
    req(1'b1, 32'h20, 4'b1000, 32'hAA000000);
    req(1'b1, 32'h20, 4'b0011, 32'h00001234);
    req(1'b0, 32'h20, 4'h0, 32'h0);
    idle(4);

    for (int i = 0; i < 4; i++) req(1'b1, 32'(i * 4), 4'hf, 32'(i + 1));
    idle(2);
    for (int i = 0; i < 4; i++) req(1'b0, 32'(i * 4), 4'hf, 32'h0);
    idle(5);

    req(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
    req(1'b0, 32'h10, 4'hf, 32'h0);
    idle(4);

    req(1'b0, 32'h10, 4'hf, 32'h0);
    req(1'b0, 32'h20, 4'hf, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    cyc = 1'b1;
    idle(5);
    req(1'b0, 32'h20, 4'hf, 32'h0);
    idle(5);

    req(1'b1, 32'h100, 4'hf, 32'h00000055);
    req(1'b0, 32'h000, 4'hf, 32'h0);
    idle(5);

    req(1'b0, 32'h10, 4'hf, 32'h0);
    req(1'b0, 32'h20, 4'hf, 32'h0);
    rst = 1'b1;
    stb = 1'b0;
    repeat (2) tick();
    release_and_count("midrst");
    req(1'b0, 32'h10, 4'hf, 32'h0);
    req(1'b0, 32'h3C, 4'hf, 32'h0);
    idle(6);

    chk("drain_L1", 32'(g_mon[0].q.size()), 32'd0);
    chk("drain_L3", 32'(g_mon[1].q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
